branch_resolve_unit: RTL and testbench

//   Consumes the flags produced by the 32-bit arithmetic unit for a
//   SUB (rs1 - rs2) compare and resolves RV32 conditional branches.
//   - Evaluates the branch condition from the flags.
//   - Computes the taken target and compares the outcome with the

---
 rtl/branch_resolve_unit_if.sv | 36 +++
 rtl/branch_resolve_unit.sv | 99 +++++++++
 tb/tb_branch_resolve_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Execute-to-fetch branch link: branch op in, registered redirect result out.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic            in_zero;
  logic            in_carry;
  logic            in_negative;
  logic            in_overflow;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_redirect;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct3, in_zero, in_carry, in_negative, in_overflow,
           in_pc, in_imm, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_redirect,
           out_redirect_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_zero, in_carry, in_negative, in_overflow,
           in_pc, in_imm, in_pred_taken, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_redirect,
           out_redirect_pc, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves RV32 conditional branches from SUB flags; registered redirect
// to fetch over valid/ready, plus saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cnt_clr,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0] cnt_branches,
  output logic [CNT_W-1:0] cnt_mispredicts
);

  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0] cnt_mp_q, cnt_mp_d;
  logic            in_ready;
  logic            accept;

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !flush;

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (bus.in_funct3)
      3'b000:  taken_d = bus.in_zero;
      3'b001:  taken_d = !bus.in_zero;
      3'b100:  taken_d = bus.in_negative ^ bus.in_overflow;
      3'b101:  taken_d = !(bus.in_negative ^ bus.in_overflow);
      3'b110:  taken_d = bus.in_carry;
      3'b111:  taken_d = !bus.in_carry;
      default: illegal_d = 1'b1;
    endcase
    target_d   = bus.in_pc + bus.in_imm;
    // Illegal ops resolve not-taken, so redirect reduces to the prediction.
    redirect_d = taken_d ^ bus.in_pred_taken;
    rpc_d      = taken_d ? target_d : bus.in_pc + XLEN'(4);
  end

  always_comb begin
    valid_d = valid_q;
    if (flush)               valid_d = 1'b0;
    else if (accept)         valid_d = 1'b1;
    else if (bus.out_ready)  valid_d = 1'b0;

    cnt_br_d = cnt_br_q;
    cnt_mp_d = cnt_mp_q;
    if (cnt_clr) begin
      cnt_br_d = '0;
      cnt_mp_d = '0;
    end else if (accept) begin
      if (cnt_br_q != '1)              cnt_br_d = cnt_br_q + 1'b1;
      if (redirect_d && cnt_mp_q != '1) cnt_mp_d = cnt_mp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      illegal_q  <= 1'b0;
      cnt_br_q   <= '0;
      cnt_mp_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      cnt_br_q <= cnt_br_d;
      cnt_mp_q <= cnt_mp_d;
      if (accept) begin
        taken_q    <= taken_d;
        target_q   <= target_d;
        redirect_q <= redirect_d;
        rpc_q      <= rpc_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = valid_q;
  assign bus.out_taken       = taken_q;
  assign bus.out_target      = target_q;
  assign bus.out_redirect    = redirect_q;
  assign bus.out_redirect_pc = rpc_q;
  assign bus.out_illegal     = illegal_q;
  assign cnt_branches        = cnt_br_q;
  assign cnt_mispredicts     = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed table, corner sequences and random
// traffic against a model that resolves branches from rs1/rs2 values.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } op_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] rpc;
    logic        illegal;
  } res_t;

  typedef struct packed {
    op_t  op;
    res_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32)) bus ();
  branch_resolve_unit_if #(.XLEN(32)) bus4 ();

  assign bus4.in_valid      = bus.in_valid;
  assign bus4.in_funct3     = bus.in_funct3;
  assign bus4.in_zero       = bus.in_zero;
  assign bus4.in_carry      = bus.in_carry;
  assign bus4.in_negative   = bus.in_negative;
  assign bus4.in_overflow   = bus.in_overflow;
  assign bus4.in_pc         = bus.in_pc;
  assign bus4.in_imm        = bus.in_imm;
  assign bus4.in_pred_taken = bus.in_pred_taken;
  assign bus4.out_ready     = bus.out_ready;

  logic [15:0] cb16, cm16;
  logic [3:0]  cb4, cm4;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr), .bus(bus),
    .cnt_branches(cb16), .cnt_mispredicts(cm16)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cnt_clr(cnt_clr), .bus(bus4),
    .cnt_branches(cb4), .cnt_mispredicts(cm4)
  );

  int checks = 0;
  int errors = 0;

  bit          exp_valid;
  res_t        exp_res;
  int unsigned m_br16, m_mp16, m_br4, m_mp4;
  op_t         cur_op;
  bit          cur_v;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t resolve(input op_t o);
    res_t r;
    r.illegal = (o.f3 == 3'd2) || (o.f3 == 3'd3);
    case (o.f3)
      3'd0:    r.taken = (o.rs1 == o.rs2);
      3'd1:    r.taken = (o.rs1 != o.rs2);
      3'd4:    r.taken = ($signed(o.rs1) <  $signed(o.rs2));
      3'd5:    r.taken = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6:    r.taken = (o.rs1 <  o.rs2);
      3'd7:    r.taken = (o.rs1 >= o.rs2);
      default: r.taken = 1'b0;
    endcase
    r.target   = o.pc + o.imm;
    r.redirect = (r.taken != o.pred);
    r.rpc      = r.taken ? r.target : o.pc + 32'd4;
    return r;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned c, input int unsigned max);
    return (c >= max) ? max : c + 1;
  endfunction

  task automatic drive(input op_t o, input bit v);
    logic [31:0] d;
    d = o.rs1 - o.rs2;
    cur_op = o;
    cur_v  = v;
    bus.in_valid      = v;
    bus.in_funct3     = o.f3;
    bus.in_zero       = (d == 32'd0);
    bus.in_carry      = (o.rs1 < o.rs2);
    bus.in_negative   = d[31];
    bus.in_overflow   = (o.rs1[31] != o.rs2[31]) && (d[31] != o.rs1[31]);
    bus.in_pc         = o.pc;
    bus.in_imm        = o.imm;
    bus.in_pred_taken = o.pred;
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_res   = '0;
    m_br16 = 0; m_mp16 = 0; m_br4 = 0; m_mp4 = 0;
  endtask

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, exp_valid);
    chk("out_valid4", bus4.out_valid, exp_valid);
    if (exp_valid) begin
      chk("out_taken", bus.out_taken, exp_res.taken);
      chk("out_target", bus.out_target, exp_res.target);
      chk("out_redirect", bus.out_redirect, exp_res.redirect);
      chk("out_redirect_pc", bus.out_redirect_pc, exp_res.rpc);
      chk("out_illegal", bus.out_illegal, exp_res.illegal);
      chk("out_redirect_pc4", bus4.out_redirect_pc, exp_res.rpc);
    end
    chk("cnt_branches", cb16, m_br16);
    chk("cnt_mispredicts", cm16, m_mp16);
    chk("cnt_branches4", cb4, m_br4);
    chk("cnt_mispredicts4", cm4, m_mp4);
  endtask

  // One clock: check in_ready, advance the model across the edge, check outputs.
  task automatic step();
    res_t r;
    bit   acc, rdy;
    #1;
    rdy = !exp_valid || bus.out_ready;
    chk("in_ready", bus.in_ready, rdy);
    acc = cur_v && rdy && !flush;
    r   = resolve(cur_op);
    @(posedge clk);
    if (flush)              exp_valid = 1'b0;
    else if (acc) begin     exp_valid = 1'b1; exp_res = r; end
    else if (bus.out_ready) exp_valid = 1'b0;
    if (cnt_clr) begin
      m_br16 = 0; m_mp16 = 0; m_br4 = 0; m_mp4 = 0;
    end else if (acc) begin
      m_br16 = sat_inc(m_br16, 65535);
      m_br4  = sat_inc(m_br4, 15);
      if (r.redirect) begin
        m_mp16 = sat_inc(m_mp16, 65535);
        m_mp4  = sat_inc(m_mp4, 15);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    op_t  o, o1, o2;
    res_t held;
    logic [15:0] sb, sm;

    tbl[0] = '{'{3'd0, 32'd9, 32'd9, 32'h1000, 32'h20, 1'b0},
               '{1'b1, 32'h1020, 1'b1, 32'h1020, 1'b0}};
    tbl[1] = '{'{3'd6, 32'd5, 32'd7, 32'h2000, 32'h40, 1'b1},
               '{1'b1, 32'h2040, 1'b0, 32'h2040, 1'b0}};
    tbl[2] = '{'{3'd7, 32'd5, 32'd7, 32'h2000, 32'h40, 1'b1},
               '{1'b0, 32'h2040, 1'b1, 32'h2004, 1'b0}};
    tbl[3] = '{'{3'd4, 32'h80000000, 32'd1, 32'h3000, 32'hFFFFFFF0, 1'b0},
               '{1'b1, 32'h2FF0, 1'b1, 32'h2FF0, 1'b0}};
    tbl[4] = '{'{3'd5, 32'h80000000, 32'd1, 32'h3000, 32'hFFFFFFF0, 1'b0},
               '{1'b0, 32'h2FF0, 1'b0, 32'h3004, 1'b0}};
    tbl[5] = '{'{3'd1, 32'd3, 32'd4, 32'hFFFFFFF0, 32'h20, 1'b1},
               '{1'b1, 32'h10, 1'b0, 32'h10, 1'b0}};
    tbl[6] = '{'{3'd2, 32'd1, 32'd1, 32'hFFFFFFFC, 32'h8, 1'b1},
               '{1'b0, 32'h4, 1'b1, 32'h0, 1'b1}};
    tbl[7] = '{'{3'd3, 32'd1, 32'd2, 32'h100, 32'h8, 1'b0},
               '{1'b0, 32'h108, 1'b0, 32'h104, 1'b1}};

    // Reset state
    model_reset();
    bus.out_ready = 1'b1;
    drive('0, 1'b0);
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_cnt_branches", cb16, 16'd0);
    chk("rst_cnt_mispredicts", cm16, 16'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].op, 1'b1);
      step();
      chk("tbl_taken", bus.out_taken, tbl[i].exp.taken);
      chk("tbl_target", bus.out_target, tbl[i].exp.target);
      chk("tbl_redirect", bus.out_redirect, tbl[i].exp.redirect);
      chk("tbl_redirect_pc", bus.out_redirect_pc, tbl[i].exp.rpc);
      chk("tbl_illegal", bus.out_illegal, tbl[i].exp.illegal);
      if (i == 0) chk("first_mispredict_cnt", cm16, 16'd1);
    end
    drive('0, 1'b0);
    step();

    // Backpressure: two ops offered while out_ready is low for three cycles
    o1 = '{3'd0, 32'd1, 32'd2, 32'h4000, 32'h10, 1'b1};
    o2 = '{3'd6, 32'd1, 32'd2, 32'h5000, 32'h30, 1'b0};
    bus.out_ready = 1'b0;
    drive(o1, 1'b1);
    step();
    held = resolve(o1);
    drive(o2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_in_ready", bus.in_ready, 1'b0);
      chk("hold_rpc", bus.out_redirect_pc, held.rpc);
      chk("hold_redirect", bus.out_redirect, held.redirect);
    end
    bus.out_ready = 1'b1;
    step();
    chk("release_target", bus.out_target, 32'h5030);
    drive('0, 1'b0);
    step();

    // Flush with a held result and a new op present
    bus.out_ready = 1'b0;
    drive(o1, 1'b1);
    step();
    sb = cb16; sm = cm16;
    flush = 1'b1;
    drive(o2, 1'b1);
    step();
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_cnt_br", cb16, sb);
    chk("flush_cnt_mp", cm16, sm);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, 1'b0);
    step();

    // Narrow counters: 17 mispredicting accepts saturate at 15
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    o = '{3'd0, 32'd7, 32'd7, 32'h600, 32'h8, 1'b0};
    drive(o, 1'b1);
    for (int k = 0; k < 17; k++) step();
    chk("sat_cnt_branches4", cb4, 4'd15);
    chk("sat_cnt_mispredicts4", cm4, 4'd15);
    cnt_clr = 1'b1;
    step();
    chk("clr_cnt_branches4", cb4, 4'd0);
    chk("clr_cnt_mispredicts4", cm4, 4'd0);
    chk("clr_cnt_branches", cb16, 16'd0);
    cnt_clr = 1'b0;

    // Asynchronous reset drops an in-flight result immediately
    bus.out_ready = 1'b0;
    drive(o, 1'b1);
    step();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_cnt_br", cb16, 16'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive('0, 1'b0);
    step();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      o.f3   = 3'($urandom_range(0, 7));
      o.rs1  = $urandom;
      case ($urandom_range(0, 3))
        0:       o.rs2 = o.rs1;
        1:       o.rs2 = o.rs1 ^ 32'h80000000;
        default: o.rs2 = $urandom;
      endcase
      o.pc   = $urandom & 32'hFFFFFFFC;
      o.imm  = {{19{1'b0}}, 13'($urandom)} - 32'h1000;
      o.pred = 1'($urandom);
      drive(o, $urandom_range(0, 3) != 0);
      bus.out_ready = $urandom_range(0, 9) < 7;
      flush   = $urandom_range(0, 19) == 0;
      cnt_clr = $urandom_range(0, 49) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
